// File: rtl/axi_wr_master.sv
// rtl/axi_wr_master.sv - single-outstanding AXI write burst master
// Takes one command plus its data beats, issues AW/W, and reports the B response.
module axi_wr_master #(
  parameter int unsigned BRESP_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_id,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [2:0]  cmd_size,
  input  logic [1:0]  cmd_burst,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  output logic        done_valid,
  output logic [3:0]  done_id,
  output logic [1:0]  done_resp,
  output logic        done_idmis,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        wvalid,
  input  logic        wready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  input  logic        bvalid,
  output logic        bready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp
);

  localparam int unsigned TW   = (BRESP_TIMEOUT > 1) ? $clog2(BRESP_TIMEOUT) : 1;
  localparam int unsigned TLIM = (BRESP_TIMEOUT == 0) ? 0 : BRESP_TIMEOUT - 1;
  localparam logic [TW-1:0] TLIM_V = TW'(TLIM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_ERR
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [3:0]   r_id;
  logic [31:0]  r_addr;
  logic [3:0]   r_len;
  logic [2:0]   r_size;
  logic [1:0]   r_burst;
  logic [3:0]   r_beat;
  logic [TW-1:0] r_tcnt;
  logic         r_done_valid;
  logic [3:0]   r_done_id;
  logic [1:0]   r_done_resp;
  logic         r_done_idmis;

  logic         w_illegal;
  logic         w_wrap_len_ok;
  logic         w_aw_hs;
  logic         w_w_hs;
  logic         w_timeout;
  logic         w_done_set;
  logic [1:0]   w_done_resp;
  logic         w_done_idmis;

  // WRAP bursts must cover 2, 4, 8 or 16 beats.
  assign w_wrap_len_ok = (cmd_len == 4'd1) || (cmd_len == 4'd3) ||
                         (cmd_len == 4'd7) || (cmd_len == 4'd15);
  assign w_illegal = (cmd_burst == 2'b11) || (cmd_size > 3'd2) ||
                     ((cmd_burst == 2'b10) && !w_wrap_len_ok);

  assign w_aw_hs   = (r_state == S_ADDR) && awready;
  assign w_w_hs    = (r_state == S_DATA) && s_wvalid && wready;
  assign w_timeout = (BRESP_TIMEOUT != 0) && (r_tcnt == TLIM_V);

  assign awid    = r_id;
  assign awaddr  = r_addr;
  assign awlen   = r_len;
  assign awsize  = r_size;
  assign awburst = r_burst;

  assign done_valid = r_done_valid;
  assign done_id    = r_done_id;
  assign done_resp  = r_done_resp;
  assign done_idmis = r_done_idmis;

  always_comb begin
    w_next       = r_state;
    cmd_ready    = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    s_wready     = 1'b0;
    wid          = 4'd0;
    wdata        = 32'd0;
    wstrb        = 4'd0;
    wlast        = 1'b0;
    bready       = 1'b0;
    w_done_set   = 1'b0;
    w_done_resp  = 2'b00;
    w_done_idmis = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_next = w_illegal ? S_ERR : S_ADDR;
        end
      end
      S_ADDR: begin
        awvalid = 1'b1;
        if (awready) begin
          w_next = S_DATA;
        end
      end
      S_DATA: begin
        wvalid   = s_wvalid;
        s_wready = wready;
        wid      = r_id;
        wdata    = s_wdata;
        wstrb    = s_wstrb;
        wlast    = (r_beat == r_len);
        if (w_w_hs && (r_beat == r_len)) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          w_done_set   = 1'b1;
          w_done_resp  = bresp;
          w_done_idmis = (bid != r_id);
          w_next       = S_IDLE;
        end else if (w_timeout) begin
          w_done_set  = 1'b1;
          w_done_resp = 2'b11;
          w_next      = S_IDLE;
        end
      end
      S_ERR: begin
        w_done_set  = 1'b1;
        w_done_resp = 2'b10;
        w_next      = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_id         <= 4'd0;
      r_addr       <= 32'd0;
      r_len        <= 4'd0;
      r_size       <= 3'd0;
      r_burst      <= 2'd0;
      r_beat       <= 4'd0;
      r_tcnt       <= '0;
      r_done_valid <= 1'b0;
      r_done_id    <= 4'd0;
      r_done_resp  <= 2'd0;
      r_done_idmis <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && cmd_valid) begin
        r_id    <= cmd_id;
        r_addr  <= cmd_addr;
        r_len   <= cmd_len;
        r_size  <= cmd_size;
        r_burst <= cmd_burst;
      end
      if (w_aw_hs) begin
        r_beat <= 4'd0;
      end else if (w_w_hs) begin
        r_beat <= r_beat + 4'd1;
      end
      // Held at zero outside RESP so every response wait starts fresh.
      if (r_state != S_RESP) begin
        r_tcnt <= '0;
      end else if (r_tcnt != TLIM_V) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      r_done_valid <= w_done_set;
      if (w_done_set) begin
        r_done_id    <= r_id;
        r_done_resp  <= w_done_resp;
        r_done_idmis <= w_done_idmis;
      end
    end
  end

endmodule
